// File: rtl/sonata_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sonata_pkg
// Brief    : Shared SPI typedefs and bit-ordering helpers for the Sonata SPI
//            target block.
// Revision : 1.0  initial release
// ============================================================================
package sonata_pkg;

   // Target-side transfer state: selected (ACTIVE) or not (IDLE).
   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_target_state_e;

   // Synchroniser reset values, packed as {sclk, cs_n, copi}.
   // CS idles high so no spurious select is seen out of reset.
   localparam logic [2:0] SpiSyncRstVal = 3'b010;

   // First bit of a byte on the wire for the given ordering.
   function automatic logic spi_first_bit(input logic [7:0] b, input logic msb_first);
      return msb_first ? b[7] : b[0];
   endfunction

   // Drop the bit just presented; fill with 1 so an exhausted register idles high.
   function automatic logic [7:0] spi_shift_out(input logic [7:0] b, input logic msb_first);
      return msb_first ? {b[6:0], 1'b1} : {1'b1, b[7:1]};
   endfunction

   // Append a received bit so that after 8 bits the byte is in natural order.
   function automatic logic [7:0] spi_shift_in(input logic [7:0] b, input logic bit_i,
                                               input logic msb_first);
      return msb_first ? {b[6:0], bit_i} : {bit_i, b[7:1]};
   endfunction

endpackage : sonata_pkg
`default_nettype wire

// File: rtl/spi_target_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_target_sync
// Brief    : N-bit multi-stage synchroniser for asynchronous SPI pins, with a
//            per-bit reset value.
// Revision : 1.0  initial release
// ============================================================================
module spi_target_sync #(
   parameter int unsigned      Width    = 1,
   parameter int unsigned      Stages   = 2,
   parameter logic [Width-1:0] ResetVal = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] sync_q [Stages];

   // Shift the raw pins through the flop chain, one stage per clock.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < Stages; i++) begin
            sync_q[i] <= ResetVal;
         end
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < Stages; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign q_o = sync_q[Stages-1];

endmodule : spi_target_sync
`default_nettype wire

// File: rtl/spi_target.sv
`default_nettype none
// ============================================================================
// Module   : spi_target
// Brief    : SPI mode-0 target with 8-bit frames, oversampled by clk_i, and
//            valid/ready byte streams for RX and TX.
// Revision : 1.0  initial release
// ============================================================================
module spi_target
   import sonata_pkg::*;
#(
   parameter int unsigned SyncStages = 2,
   parameter logic        MsbFirst   = 1'b1,
   parameter logic [7:0]  TxIdleByte = 8'hFF
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       sclk_i,
   input  logic       cs_ni,
   input  logic       copi_i,
   output logic       cipo_o,
   output logic       cipo_en_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic       rx_overflow_o,
   output logic       tx_underrun_o,
   output logic       xfer_end_o
);

   // ---------------------------------------------------------------------
   // Pin synchronisation and edge detection
   // ---------------------------------------------------------------------
   logic sclk_s, cs_n_s, copi_s;
   logic sclk_prev_q, cs_n_prev_q;

   spi_target_sync #(
      .Width    (3),
      .Stages   (SyncStages),
      .ResetVal (SpiSyncRstVal)
   ) u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    ({sclk_i, cs_ni, copi_i}),
      .q_o    ({sclk_s, cs_n_s, copi_s})
   );

   // Remember the previous synced SCLK/CS sample for edge detection.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sclk_prev_q <= 1'b0;
         cs_n_prev_q <= 1'b1;
      end else begin
         sclk_prev_q <= sclk_s;
         cs_n_prev_q <= cs_n_s;
      end
   end

   logic sclk_rise, sclk_fall, cs_fall, cs_rise;
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign cs_fall   = ~cs_n_s & cs_n_prev_q;
   assign cs_rise   = cs_n_s & ~cs_n_prev_q;

   // ---------------------------------------------------------------------
   // Datapath and control state
   // ---------------------------------------------------------------------
   spi_target_state_e state_q, state_d;
   logic [2:0] bit_cnt_q,   bit_cnt_d;
   logic [7:0] rx_shift_q,  rx_shift_d;
   logic [7:0] rx_data_q,   rx_data_d;
   logic       rx_valid_q,  rx_valid_d;
   logic [7:0] tx_shift_q,  tx_shift_d;
   logic       cipo_q,      cipo_d;
   logic [7:0] tx_hold_q,   tx_hold_d;
   logic       tx_full_q,   tx_full_d;
   logic       load_pend_q, load_pend_d;
   logic       rx_ovf_q,    rx_ovf_d;
   logic       tx_und_q,    tx_und_d;
   logic       xfer_end_q,  xfer_end_d;

   logic       do_load;
   logic       rx_done;
   logic [7:0] rx_byte;
   logic [7:0] load_byte;

   // Next-state logic: FSM, bit counter, shift registers and both handshakes.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_shift_d  = rx_shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      tx_shift_d  = tx_shift_q;
      cipo_d      = cipo_q;
      tx_hold_d   = tx_hold_q;
      tx_full_d   = tx_full_q;
      load_pend_d = load_pend_q;
      rx_ovf_d    = 1'b0;
      tx_und_d    = 1'b0;
      xfer_end_d  = 1'b0;
      do_load     = 1'b0;
      rx_done     = 1'b0;
      rx_byte     = spi_shift_in(rx_shift_q, copi_s, MsbFirst);
      load_byte   = TxIdleByte;

      // Consumer took the current byte; a byte landing this cycle re-sets valid below.
      if (rx_valid_q && rx_ready_i) begin
         rx_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            // SCLK activity while deselected is ignored.
            if (cs_fall) begin
               state_d     = ACTIVE;
               bit_cnt_d   = 3'd0;
               rx_shift_d  = 8'h00;
               load_pend_d = 1'b0;
               do_load     = 1'b1;
            end
         end
         ACTIVE: begin
            if (cs_rise) begin
               // Deselect wins over any coincident SCLK edge; partial bytes are dropped.
               state_d     = IDLE;
               xfer_end_d  = 1'b1;
               bit_cnt_d   = 3'd0;
               rx_shift_d  = 8'h00;
               load_pend_d = 1'b0;
               tx_shift_d  = 8'hFF;
               cipo_d      = 1'b1;
            end else if (sclk_rise) begin
               rx_shift_d = rx_byte;
               bit_cnt_d  = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  rx_done     = 1'b1;
                  load_pend_d = 1'b1;
               end
            end else if (sclk_fall) begin
               if (load_pend_q) begin
                  do_load     = 1'b1;
                  load_pend_d = 1'b0;
               end else begin
                  cipo_d     = spi_first_bit(tx_shift_q, MsbFirst);
                  tx_shift_d = spi_shift_out(tx_shift_q, MsbFirst);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Completed byte: deliver if the output register is free or being drained.
      if (rx_done) begin
         if (!rx_valid_q || rx_ready_i) begin
            rx_data_d  = rx_byte;
            rx_valid_d = 1'b1;
         end else begin
            rx_ovf_d = 1'b1;
         end
      end

      // TX load takes priority over filling the holding register; a byte offered
      // while the holding register is empty goes straight to the shifter.
      if (do_load) begin
         if (tx_full_q) begin
            load_byte = tx_hold_q;
            tx_full_d = 1'b0;
         end else if (tx_valid_i) begin
            load_byte = tx_data_i;
         end else begin
            load_byte = TxIdleByte;
            tx_und_d  = 1'b1;
         end
         cipo_d     = spi_first_bit(load_byte, MsbFirst);
         tx_shift_d = spi_shift_out(load_byte, MsbFirst);
      end else if (tx_valid_i && !tx_full_q) begin
         tx_hold_d = tx_data_i;
         tx_full_d = 1'b1;
      end
   end

   // State registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         bit_cnt_q   <= 3'd0;
         rx_shift_q  <= 8'h00;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         tx_shift_q  <= 8'hFF;
         cipo_q      <= 1'b1;
         tx_hold_q   <= 8'h00;
         tx_full_q   <= 1'b0;
         load_pend_q <= 1'b0;
         rx_ovf_q    <= 1'b0;
         tx_und_q    <= 1'b0;
         xfer_end_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         tx_shift_q  <= tx_shift_d;
         cipo_q      <= cipo_d;
         tx_hold_q   <= tx_hold_d;
         tx_full_q   <= tx_full_d;
         load_pend_q <= load_pend_d;
         rx_ovf_q    <= rx_ovf_d;
         tx_und_q    <= tx_und_d;
         xfer_end_q  <= xfer_end_d;
      end
   end

   assign cipo_o        = cipo_q;
   assign cipo_en_o     = (state_q == ACTIVE);
   assign rx_data_o     = rx_data_q;
   assign rx_valid_o    = rx_valid_q;
   assign tx_ready_o    = ~tx_full_q;
   assign rx_overflow_o = rx_ovf_q;
   assign tx_underrun_o = tx_und_q;
   assign xfer_end_o    = xfer_end_q;

endmodule : spi_target
`default_nettype wire

// File: tb/tb_spi_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_target
// Brief    : Directed testbench for spi_target: an MSB-first instance and an
//            LSB-first instance share one mode-0 host model.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_target;

   localparam int HPC = 8;  // clk_i cycles per SCLK half period (16x ratio)

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic sclk = 1'b0;
   logic cs_n = 1'b1;
   logic copi = 1'b0;

   // MSB-first instance
   logic       cipo_m, cipo_en_m, rx_valid_m, tx_ready_m, ovf_m, und_m, xend_m;
   logic [7:0] rx_data_m;
   logic       rx_ready_m = 1'b0;
   logic [7:0] tx_data_m  = 8'h00;
   logic       tx_valid_m = 1'b0;

   // LSB-first instance
   logic       cipo_l, cipo_en_l, rx_valid_l, tx_ready_l, ovf_l, und_l, xend_l;
   logic [7:0] rx_data_l;
   logic       rx_ready_l = 1'b1;
   logic [7:0] tx_data_l  = 8'h00;
   logic       tx_valid_l = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   int ovf_cnt = 0, und_cnt = 0, xend_cnt = 0, rxv_cnt = 0;
   logic rxv_prev = 1'b0;

   always #5 clk = ~clk;

   spi_target #(.SyncStages(2), .MsbFirst(1'b1), .TxIdleByte(8'hFF)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .sclk_i(sclk), .cs_ni(cs_n), .copi_i(copi),
      .cipo_o(cipo_m), .cipo_en_o(cipo_en_m),
      .rx_data_o(rx_data_m), .rx_valid_o(rx_valid_m), .rx_ready_i(rx_ready_m),
      .tx_data_i(tx_data_m), .tx_valid_i(tx_valid_m), .tx_ready_o(tx_ready_m),
      .rx_overflow_o(ovf_m), .tx_underrun_o(und_m), .xfer_end_o(xend_m)
   );

   spi_target #(.SyncStages(2), .MsbFirst(1'b0), .TxIdleByte(8'hFF)) u_dut_lsb (
      .clk_i(clk), .rst_ni(rst_n), .sclk_i(sclk), .cs_ni(cs_n), .copi_i(copi),
      .cipo_o(cipo_l), .cipo_en_o(cipo_en_l),
      .rx_data_o(rx_data_l), .rx_valid_o(rx_valid_l), .rx_ready_i(rx_ready_l),
      .tx_data_i(tx_data_l), .tx_valid_i(tx_valid_l), .tx_ready_o(tx_ready_l),
      .rx_overflow_o(ovf_l), .tx_underrun_o(und_l), .xfer_end_o(xend_l)
   );

   // Pulse and new-byte counters for the MSB-first instance.
   always @(posedge clk) begin
      if (ovf_m)                   ovf_cnt  <= ovf_cnt + 1;
      if (und_m)                   und_cnt  <= und_cnt + 1;
      if (xend_m)                  xend_cnt <= xend_cnt + 1;
      if (rx_valid_m && !rxv_prev) rxv_cnt  <= rxv_cnt + 1;
      rxv_prev <= rx_valid_m;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_tx(input bit lsb, input logic [7:0] d);
      int t;
      t = 0;
      @(negedge clk);
      while (!(lsb ? tx_ready_l : tx_ready_m) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) chk("tx_ready_timeout", 32'd0, 32'd1);
      if (lsb) begin tx_data_l = d; tx_valid_l = 1'b1; end
      else     begin tx_data_m = d; tx_valid_m = 1'b1; end
      @(negedge clk);
      tx_valid_l = 1'b0;
      tx_valid_m = 1'b0;
   endtask

   task automatic accept_rx();
      @(negedge clk);
      rx_ready_m = 1'b1;
      @(negedge clk);
      rx_ready_m = 1'b0;
   endtask

   // Mode-0 host: drive before the rise, sample on the rise, change on the fall.
   task automatic host_frame(input logic [7:0] mosi, input int nbits, input bit lsb,
                             output logic [7:0] miso);
      miso = 8'h00;
      @(negedge clk);
      cs_n = 1'b0;
      copi = lsb ? mosi[0] : mosi[7];
      repeat (HPC) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         sclk = 1'b1;
         if (lsb) miso[i] = cipo_l;
         else     miso[7-i] = cipo_m;
         repeat (HPC) @(negedge clk);
         sclk = 1'b0;
         if (i + 1 < 8) copi = lsb ? mosi[i+1] : mosi[6-i];
         repeat (HPC) @(negedge clk);
      end
      cs_n = 1'b1;
      copi = 1'b0;
      repeat (2*HPC) @(negedge clk);
   endtask

   typedef struct {
      logic [7:0] mosi;
      logic [7:0] hold;
      logic [7:0] exp_rx;
      logic [7:0] exp_miso;
   } vec_t;

   vec_t vecs[5];

   initial begin
      logic [7:0] miso;
      int ovf_b, und_b, xend_b, rxv_b;

      vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
      vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
      vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
      vecs[3] = '{8'h81, 8'h7E, 8'h81, 8'h7E};
      vecs[4] = '{8'h5A, 8'hC3, 8'h5A, 8'hC3};

      // Reset values
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cipo",     {31'd0, cipo_m},     32'd1);
      chk("rst_cipo_en",  {31'd0, cipo_en_m},  32'd0);
      chk("rst_rx_data",  {24'd0, rx_data_m},  32'h00);
      chk("rst_rx_valid", {31'd0, rx_valid_m}, 32'd0);
      chk("rst_tx_ready", {31'd0, tx_ready_m}, 32'd1);
      chk("rst_pulses",   {29'd0, ovf_m, und_m, xend_m}, 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Table: full frames with TX data preloaded in the holding register
      for (int i = 0; i < 5; i++) begin
         push_tx(1'b0, vecs[i].hold);
         host_frame(vecs[i].mosi, 8, 1'b0, miso);
         chk($sformatf("vec%0d_rx_data", i),  {24'd0, rx_data_m},  {24'd0, vecs[i].exp_rx});
         chk($sformatf("vec%0d_rx_valid", i), {31'd0, rx_valid_m}, 32'd1);
         chk($sformatf("vec%0d_miso", i),     {24'd0, miso},       {24'd0, vecs[i].exp_miso});
         accept_rx();
      end

      // Overflow: two bytes with the consumer stalled
      ovf_b = ovf_cnt;
      host_frame(8'h01, 8, 1'b0, miso);
      host_frame(8'h02, 8, 1'b0, miso);
      chk("ovf_rx_data",  {24'd0, rx_data_m},  32'h01);
      chk("ovf_rx_valid", {31'd0, rx_valid_m}, 32'd1);
      chk("ovf_pulses",   ovf_cnt - ovf_b,     32'd1);
      accept_rx();
      repeat (2) @(negedge clk);
      chk("ovf_valid_clr", {31'd0, rx_valid_m}, 32'd0);

      // Underrun at CS fall; a byte arriving mid-frame covers the next load
      und_b = und_cnt;
      fork
         host_frame(8'h33, 8, 1'b0, miso);
         begin
            repeat (HPC + 4) @(negedge clk);
            push_tx(1'b0, 8'h12);
         end
      join
      chk("und_miso",   {24'd0, miso},   32'hFF);
      chk("und_pulses", und_cnt - und_b, 32'd1);
      accept_rx();

      // CS raised after 5 bits, then a clean frame
      xend_b = xend_cnt;
      rxv_b  = rxv_cnt;
      host_frame(8'hF0, 5, 1'b0, miso);
      chk("abort_no_valid", rxv_cnt - rxv_b,       32'd0);
      chk("abort_rx_valid", {31'd0, rx_valid_m},   32'd0);
      chk("abort_xfer_end", xend_cnt - xend_b,     32'd1);
      push_tx(1'b0, 8'h96);
      host_frame(8'h81, 8, 1'b0, miso);
      chk("post_abort_rx",   {24'd0, rx_data_m}, 32'h81);
      chk("post_abort_miso", {24'd0, miso},      32'h96);
      accept_rx();

      // LSB-first instance
      push_tx(1'b1, 8'h80);
      host_frame(8'h01, 8, 1'b1, miso);
      chk("lsb_rx_data",      {24'd0, rx_data_l}, 32'h01);
      chk("lsb_miso",         {24'd0, miso},      32'h80);
      chk("lsb_wire_on_msb",  {24'd0, rx_data_m}, 32'h80);
      accept_rx();

      // Asynchronous reset in the middle of a frame
      push_tx(1'b0, 8'h11);
      fork
         host_frame(8'hAA, 8, 1'b0, miso);
         begin
            repeat (40) @(negedge clk);
            #3 rst_n = 1'b0;
            #1;
            chk("mid_rst_cipo",     {31'd0, cipo_m},     32'd1);
            chk("mid_rst_cipo_en",  {31'd0, cipo_en_m},  32'd0);
            chk("mid_rst_rx_data",  {24'd0, rx_data_m},  32'h00);
            chk("mid_rst_rx_valid", {31'd0, rx_valid_m}, 32'd0);
            chk("mid_rst_tx_ready", {31'd0, tx_ready_m}, 32'd1);
         end
      join
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      push_tx(1'b0, 8'hC3);
      host_frame(8'h5A, 8, 1'b0, miso);
      chk("post_rst_rx",    {24'd0, rx_data_m},  32'h5A);
      chk("post_rst_valid", {31'd0, rx_valid_m}, 32'd1);
      chk("post_rst_miso",  {24'd0, miso},       32'hC3);
      accept_rx();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Watchdog so the run always ends on its own.
   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_spi_target
`default_nettype wire
